// File: rtl/agex_mdu_sequencer_if.sv
// AGEX <-> MDU handshake bundle: start/operands/flush in, stall/result out.
// Latency: none (wires only).
// Backpressure: the MDU holds the pipeline through stall_out.
interface agex_mdu_sequencer_if #(
  parameter int DBITS = 32
);
  logic             start_valid;
  logic [2:0]       mdu_op;
  logic [DBITS-1:0] rs1_val;
  logic [DBITS-1:0] rs2_val;
  logic             flush;
  logic             stall_out;
  logic             result_valid;
  logic [DBITS-1:0] result;

  // AGEX side drives the request and observes stall/result
  modport master (
    output start_valid, mdu_op, rs1_val, rs2_val, flush,
    input  stall_out, result_valid, result
  );

  // MDU side
  modport slave (
    input  start_valid, mdu_op, rs1_val, rs2_val, flush,
    output stall_out, result_valid, result
  );
endinterface

// File: rtl/agex_mdu_sequencer.sv
// Iterative RV32M multiply/divide sequencer attached to AGEX (shift-add / restoring divide).
// Latency: DBITS+1 cycles start->result_valid; divide-by-zero (and zero operands with MDU_FASTZERO_EN) in 1 cycle.
// Backpressure: stall_out holds FE/DE/AGEX until DONE; flush kills the op and drops stall/result_valid at once.
module agex_mdu_sequencer #(
  parameter int DBITS    = 32,
  parameter int CNT_BITS = 6
) (
  input  logic                clk,
  input  logic                reset,
  agex_mdu_sequencer_if.slave mdu
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;          // product / quotient sign
  logic               rem_neg_q, rem_neg_d;  // remainder follows dividend sign
  logic [DBITS-1:0]   dvsr_q, dvsr_d;        // multiplicand or divisor magnitude
  logic [DBITS-1:0]   hi_q, hi_d;            // product high half / partial remainder
  logic [DBITS-1:0]   lo_q, lo_d;            // multiplier shifting out / quotient shifting in
  logic [DBITS-1:0]   result_q, result_d;

  // Operand decode: which sources are signed for this funct3
  logic             is_div, rs1_sgn, rs2_sgn, rs1_neg, rs2_neg;
  logic             div_zero, fast_zero, start_go;
  logic [DBITS-1:0] rs1_mag, rs2_mag;

  assign is_div   = mdu.mdu_op[2];
  assign rs1_sgn  = is_div ? ~mdu.mdu_op[0]
                           : (mdu.mdu_op[1:0] == 2'b01) || (mdu.mdu_op[1:0] == 2'b10);
  assign rs2_sgn  = is_div ? ~mdu.mdu_op[0] : (mdu.mdu_op[1:0] == 2'b01);
  assign rs1_neg  = rs1_sgn & mdu.rs1_val[DBITS-1];
  assign rs2_neg  = rs2_sgn & mdu.rs2_val[DBITS-1];
  assign rs1_mag  = rs1_neg ? ('0 - mdu.rs1_val) : mdu.rs1_val;
  assign rs2_mag  = rs2_neg ? ('0 - mdu.rs2_val) : mdu.rs2_val;
  assign div_zero = is_div && (mdu.rs2_val == '0);
  assign start_go = (state_q == IDLE) && mdu.start_valid && !mdu.flush;

`ifdef MDU_FASTZERO_EN
  // Zero operands make the answer trivially 0, so skip the iterations
  assign fast_zero = is_div ? (mdu.rs1_val == '0)
                            : (mdu.rs1_val == '0) || (mdu.rs2_val == '0);
`else
  assign fast_zero = 1'b0;
`endif

  // One radix-2 step of either engine
  logic [DBITS:0]   mul_sum, div_diff;
  logic [DBITS-1:0] step_hi, step_lo;

  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dvsr_q} : '0);
  assign div_diff = {hi_q, lo_q[DBITS-1]} - {1'b0, dvsr_q};

  always_comb begin
    step_hi = hi_q;
    step_lo = lo_q;
    if (!op_q[2]) begin
      step_hi = mul_sum[DBITS:1];
      step_lo = {mul_sum[0], lo_q[DBITS-1:1]};
    end else if (!div_diff[DBITS]) begin
      step_hi = div_diff[DBITS-1:0];
      step_lo = {lo_q[DBITS-2:0], 1'b1};
    end else begin
      step_hi = {hi_q[DBITS-2:0], lo_q[DBITS-1]};
      step_lo = {lo_q[DBITS-2:0], 1'b0};
    end
  end

  // Sign correction and result select on the final step
  logic [2*DBITS-1:0] prod, prod_s;
  logic [DBITS-1:0]   quo_s, rem_s, final_res;

  assign prod   = {step_hi, step_lo};
  assign prod_s = neg_q ? ('0 - prod) : prod;
  assign quo_s  = neg_q ? ('0 - step_lo) : step_lo;
  assign rem_s  = rem_neg_q ? ('0 - step_hi) : step_hi;

  always_comb begin
    final_res = '0;
    case (op_q)
      3'b000:                 final_res = prod_s[DBITS-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*DBITS-1:DBITS];
      3'b100, 3'b101:         final_res = quo_s;
      default:                final_res = rem_s;
    endcase
  end

  // Next-state and datapath update; flush wins over everything
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    dvsr_d    = dvsr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    result_d  = result_q;
    case (state_q)
      IDLE: begin
        if (start_go) begin
          op_d      = mdu.mdu_op;
          neg_d     = rs1_neg ^ rs2_neg;
          rem_neg_d = rs1_neg;
          dvsr_d    = is_div ? rs2_mag : rs1_mag;
          lo_d      = is_div ? rs1_mag : rs2_mag;
          hi_d      = '0;
          if (div_zero) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = mdu.mdu_op[1] ? mdu.rs1_val : '1;
          end else if (fast_zero) begin
            state_d  = DONE;
            cnt_d    = '0;
            result_d = '0;
          end else begin
            state_d  = BUSY;
            cnt_d    = CNT_BITS'(DBITS);
          end
        end
      end
      BUSY: begin
        hi_d  = step_hi;
        lo_d  = step_lo;
        cnt_d = cnt_q - CNT_BITS'(1);
        if (cnt_q == CNT_BITS'(1)) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mdu.flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      result_d = result_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      dvsr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      dvsr_q    <= dvsr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      result_q  <= result_d;
    end
  end

  assign mdu.stall_out    = !mdu.flush &&
                            (((state_q == IDLE) && mdu.start_valid) || (state_q == BUSY));
  assign mdu.result_valid = (state_q == DONE) && !mdu.flush;
  assign mdu.result       = result_q;

endmodule
